// File: rtl/bytecode_fetch_sequencer.sv
// Bytecode fetch sequencer: walks a Java bytecode ROM and issues one
// opcode+operands record per valid/ready transfer to the ARM generator.
module bytecode_fetch_sequencer #(
  parameter int          ADDR_W      = 8,
  parameter logic [7:0]  HALT_OPCODE = 8'hB1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_opcode,
  output logic [7:0]        out_op1,
  output logic [7:0]        out_op2,
  output logic [1:0]        out_num_ops,
  output logic [ADDR_W-1:0] out_pc,
  output logic              busy,
  output logic              halted,
  output logic              illegal
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FOP   = 3'd1;
  localparam logic [2:0] S_DEC   = 3'd2;
  localparam logic [2:0] S_FOPND = 3'd3;
  localparam logic [2:0] S_CAP   = 3'd4;
  localparam logic [2:0] S_ISSUE = 3'd5;
  localparam logic [2:0] S_HALT  = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] opc_pc_q, opc_pc_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [7:0]        op1_q, op1_d;
  logic [7:0]        op2_q, op2_d;
  logic [1:0]        num_q, num_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              halted_q, halted_d;
  logic              illegal_q, illegal_d;
  logic [2:0]        cls;

  // {legal, operand count}
  function automatic logic [2:0] classify(input logic [7:0] op);
    case (op) inside
      8'h00, [8'h03:8'h08], [8'h1A:8'h1D],
      [8'h3B:8'h3E], 8'h60, 8'h64, 8'hB1:
        classify = 3'b100;
      8'h10, 8'h15, 8'h36:
        classify = 3'b101;
      8'h11, 8'h84, 8'hA7:
        classify = 3'b110;
      default:
        classify = 3'b000;
    endcase
  endfunction

  assign cls = classify(rom_data);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opc_pc_d  = opc_pc_q;
    opcode_d  = opcode_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    num_d     = num_q;
    cnt_d     = cnt_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    rom_en    = 1'b0;
    rom_addr  = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = start_pc;
          state_d = S_FOP;
        end
      end
      S_FOP: begin
        rom_en   = 1'b1;
        rom_addr = pc_q;
        opc_pc_d = pc_q;
        pc_d     = pc_q + 1'b1;
        state_d  = S_DEC;
      end
      S_DEC: begin
        opcode_d = rom_data;
        op1_d    = '0;
        op2_d    = '0;
        cnt_d    = '0;
        num_d    = cls[1:0];
        if (!cls[2]) begin
          halted_d  = 1'b1;
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else if (cls[1:0] == 2'd0) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_FOPND;
        end
      end
      S_FOPND: begin
        rom_en   = 1'b1;
        rom_addr = pc_q;
        pc_d     = pc_q + 1'b1;
        state_d  = S_CAP;
      end
      S_CAP: begin
        if (cnt_q == 2'd0) op1_d = rom_data;
        else               op2_d = rom_data;
        cnt_d   = cnt_q + 2'd1;
        state_d = (cnt_d < num_q) ? S_FOPND : S_ISSUE;
      end
      S_ISSUE: begin
        if (out_ready) begin
          if (opcode_q == HALT_OPCODE) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            state_d = S_FOP;
          end
        end
      end
      S_HALT: begin
        if (start) begin
          halted_d  = 1'b0;
          illegal_d = 1'b0;
          pc_d      = start_pc;
          state_d   = S_FOP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      opc_pc_q  <= '0;
      opcode_q  <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      num_q     <= '0;
      cnt_q     <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opc_pc_q  <= opc_pc_d;
      opcode_q  <= opcode_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      num_q     <= num_d;
      cnt_q     <= cnt_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid   = (state_q == S_ISSUE);
  assign out_opcode  = opcode_q;
  assign out_op1     = op1_q;
  assign out_op2     = op2_q;
  assign out_num_ops = num_q;
  assign out_pc      = opc_pc_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted      = halted_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_bytecode_fetch_sequencer.sv
// Directed bench for bytecode_fetch_sequencer with a 1-cycle-latency ROM.
module tb_bytecode_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] start_pc;
  logic       rom_en;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_opcode, out_op1, out_op2;
  logic [1:0] out_num_ops;
  logic [7:0] out_pc;
  logic       busy, halted, illegal;

  logic [7:0] rom [256];
  int ncmp  = 0;
  int nfail = 0;
  int xfers = 0;
  int x0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rom_en) rom_data <= rom[rom_addr];

  always @(negedge clk)
    if (out_valid && out_ready) xfers++;

  bytecode_fetch_sequencer #(.ADDR_W(8), .HALT_OPCODE(8'hB1)) dut (
    .clk(clk), .reset(rst_n), .start(start), .start_pc(start_pc),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_op1(out_op1), .out_op2(out_op2),
    .out_num_ops(out_num_ops), .out_pc(out_pc),
    .busy(busy), .halted(halted), .illegal(illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rec(input string tag, input logic [7:0] op,
                     input logic [7:0] o1, input logic [7:0] o2,
                     input logic [1:0] n, input logic [7:0] pc);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".opc"}, {24'd0, out_opcode}, {24'd0, op});
    chk({tag, ".op1"}, {24'd0, out_op1}, {24'd0, o1});
    chk({tag, ".op2"}, {24'd0, out_op2}, {24'd0, o2});
    chk({tag, ".num"}, {30'd0, out_num_ops}, {30'd0, n});
    chk({tag, ".pc"}, {24'd0, out_pc}, {24'd0, pc});
  endtask

  task automatic idle_zero(input string tag);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
    chk({tag, ".romen"}, {31'd0, rom_en}, 32'd0);
    chk({tag, ".addr"}, {24'd0, rom_addr}, 32'd0);
    chk({tag, ".opc"}, {24'd0, out_opcode}, 32'd0);
    chk({tag, ".op1"}, {24'd0, out_op1}, 32'd0);
    chk({tag, ".op2"}, {24'd0, out_op2}, 32'd0);
    chk({tag, ".num"}, {30'd0, out_num_ops}, 32'd0);
    chk({tag, ".pc"}, {24'd0, out_pc}, 32'd0);
    chk({tag, ".halted"}, {31'd0, halted}, 32'd0);
    chk({tag, ".illegal"}, {31'd0, illegal}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rst_n = 1'b0; start = 1'b0; start_pc = 8'h00; out_ready = 1'b1;
    #3;
    idle_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    tick();

    // iconst_2 then return
    rom[0] = 8'h05; rom[1] = 8'hB1;
    start_pc = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1.c1.romen", {31'd0, rom_en}, 32'd1);
    chk("t1.c1.addr", {24'd0, rom_addr}, 32'h00);
    chk("t1.c1.busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t1.c2.valid", {31'd0, out_valid}, 32'd0);
    tick();
    rec("t1.c3", 8'h05, 8'h00, 8'h00, 2'd0, 8'h00);
    tick();
    chk("t1.c4.romen", {31'd0, rom_en}, 32'd1);
    chk("t1.c4.addr", {24'd0, rom_addr}, 32'h01);
    tick(); tick();
    rec("t1.c6", 8'hB1, 8'h00, 8'h00, 2'd0, 8'h01);
    tick();
    chk("t1.halted", {31'd0, halted}, 32'd1);
    chk("t1.illegal", {31'd0, illegal}, 32'd0);
    chk("t1.busy", {31'd0, busy}, 32'd0);
    chk("t1.valid", {31'd0, out_valid}, 32'd0);

    // bipush 0x7F then return, restarted from HALT
    rom[10] = 8'h10; rom[11] = 8'h7F; rom[12] = 8'hB1;
    start_pc = 8'd10; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2.c1.halted", {31'd0, halted}, 32'd0);
    repeat (4) tick();
    rec("t2.c5", 8'h10, 8'h7F, 8'h00, 2'd1, 8'd10);
    tick();
    chk("t2.c6.addr", {24'd0, rom_addr}, 32'd12);
    tick(); tick();
    rec("t2.c8", 8'hB1, 8'h00, 8'h00, 2'd0, 8'd12);
    tick();
    chk("t2.halted", {31'd0, halted}, 32'd1);

    // sipush with backpressure
    rom[0] = 8'h11; rom[1] = 8'h12; rom[2] = 8'h34; rom[3] = 8'hB1;
    out_ready = 1'b0;
    x0 = xfers;
    start_pc = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    for (int i = 0; i < 4; i++) begin
      rec("t3.hold", 8'h11, 8'h12, 8'h34, 2'd2, 8'h00);
      if (i == 3) out_ready = 1'b1;
      tick();
    end
    chk("t3.c11.valid", {31'd0, out_valid}, 32'd0);
    chk("t3.c11.romen", {31'd0, rom_en}, 32'd1);
    chk("t3.c11.addr", {24'd0, rom_addr}, 32'h03);
    chk("t3.xfer1", xfers - x0, 32'd1);
    tick(); tick();
    rec("t3.c13", 8'hB1, 8'h00, 8'h00, 2'd0, 8'h03);
    tick();
    chk("t3.halted", {31'd0, halted}, 32'd1);
    chk("t3.xfer2", xfers - x0, 32'd2);

    // illegal opcode, then restart clears flags
    rom[0] = 8'hFF;
    x0 = xfers;
    start_pc = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t4.c2.valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t4.halted", {31'd0, halted}, 32'd1);
    chk("t4.illegal", {31'd0, illegal}, 32'd1);
    chk("t4.valid", {31'd0, out_valid}, 32'd0);
    chk("t4.busy", {31'd0, busy}, 32'd0);
    chk("t4.noxfer", xfers - x0, 32'd0);
    rom[8'h20] = 8'h00; rom[8'h21] = 8'hB1;
    start_pc = 8'h20; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4.r.halted", {31'd0, halted}, 32'd0);
    chk("t4.r.illegal", {31'd0, illegal}, 32'd0);
    chk("t4.r.addr", {24'd0, rom_addr}, 32'h20);
    tick(); tick();
    rec("t4.c3", 8'h00, 8'h00, 8'h00, 2'd0, 8'h20);
    repeat (3) tick();
    rec("t4.c6", 8'hB1, 8'h00, 8'h00, 2'd0, 8'h21);
    tick();
    chk("t4.r.halt", {31'd0, halted}, 32'd1);
    chk("t4.r.ill", {31'd0, illegal}, 32'd0);

    // operand straddles pc wrap
    rom[8'hFF] = 8'h10; rom[0] = 8'h2A; rom[1] = 8'hB1;
    start_pc = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5.c1.addr", {24'd0, rom_addr}, 32'hFF);
    repeat (4) tick();
    rec("t5.c5", 8'h10, 8'h2A, 8'h00, 2'd1, 8'hFF);
    tick();
    chk("t5.c6.romen", {31'd0, rom_en}, 32'd1);
    chk("t5.c6.addr", {24'd0, rom_addr}, 32'h01);
    tick(); tick();
    rec("t5.c8", 8'hB1, 8'h00, 8'h00, 2'd0, 8'h01);
    tick();
    chk("t5.halted", {31'd0, halted}, 32'd1);

    // start while busy ignored; reset during CAP_OPND
    rom[8'h40] = 8'h11; rom[8'h41] = 8'hAA;
    rom[8'h42] = 8'hBB; rom[8'h43] = 8'hB1;
    start_pc = 8'h40; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start_pc = 8'h80; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6.c3.addr", {24'd0, rom_addr}, 32'h41);
    tick();
    chk("t6.c4.romen", {31'd0, rom_en}, 32'd0);
    chk("t6.c4.busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    idle_zero("t6.rst");
    @(negedge clk) rst_n = 1'b1;
    tick();
    start_pc = 8'h40; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6.r.addr", {24'd0, rom_addr}, 32'h40);
    repeat (6) tick();
    rec("t6.c7", 8'h11, 8'hAA, 8'hBB, 2'd2, 8'h40);
    tick();
    chk("t6.c8.addr", {24'd0, rom_addr}, 32'h43);
    tick(); tick();
    rec("t6.c10", 8'hB1, 8'h00, 8'h00, 2'd0, 8'h43);
    tick();
    chk("t6.halted", {31'd0, halted}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
